mirfak_if_stage: RTL

Instruction Fetch stage and IF/ID pipeline register. It holds the program counter, fetches instructions over the classic Wishbone instruction port, and redirects on branch/jump targets from ID or trap/return targets from the CSR unit. It feeds `mirfak_id_stage` with pc, pc+4, instruction, fetch exception and bubble flag. When no instruction is ready, it inserts a NOP bubble rather than stalling the pipe.

---
 rtl/mirfak_if_stage_pkg.sv | 17 +
 rtl/mirfak_if_stage_if.sv | 12 +
 rtl/mirfak_if_fetch_buffer.sv | 56 +++++
 rtl/mirfak_if_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mirfak_if_stage_pkg.sv
// Shared definitions for the mirfak fetch stage: NOP encoding, fetch exception causes, FSM states.
package mirfak_if_stage_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [3:0] E_INST_ADDR_MISALIGNED = 4'd0;
  localparam logic [3:0] E_INST_ACCESS_FAULT    = 4'd1;
  localparam logic [3:0] E_ILLEGAL_INST         = 4'd2;
  localparam logic [3:0] E_BREAKPOINT           = 4'd3;

  typedef enum logic [1:0] {
    StReset = 2'd0,
    StFetch = 2'd1,
    StFlush = 2'd2
  } if_state_e;

endpackage

// File: rtl/mirfak_if_stage_if.sv
// Classic Wishbone instruction port: addr/cyc/stb out of the fetch stage, data/ack/err back in.
interface mirfak_if_stage_if;
  logic [31:0] addr;
  logic        cyc;
  logic        stb;
  logic [31:0] data;
  logic        ack;
  logic        err;

  modport master (output addr, cyc, stb, input data, ack, err);
  modport slave  (input addr, cyc, stb, output data, ack, err);
endinterface

// File: rtl/mirfak_if_fetch_buffer.sv
// One-entry holding slot for a fetch response that arrived while IF/ID was not enabled.
// Only built when MIRFAK_IF_BUFFER_EN is defined.
`ifdef MIRFAK_IF_BUFFER_EN
module mirfak_if_fetch_buffer
  import mirfak_if_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        exc_i,
  output logic        full_o,
  output logic        full_next_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        exc_o
);

  logic        full_q, full_d;
  logic [31:0] pc_q, instr_q;
  logic        exc_q;

  always_comb begin
    full_d = full_q;
    if (flush_i)     full_d = 1'b0;
    else if (push_i) full_d = 1'b1;
    else if (pop_i)  full_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP;
      exc_q   <= 1'b0;
    end else begin
      full_q <= full_d;
      if (push_i && !flush_i) begin
        pc_q    <= pc_i;
        instr_q <= instr_i;
        exc_q   <= exc_i;
      end
    end
  end

  assign full_o      = full_q;
  assign full_next_o = full_d;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;
  assign exc_o       = exc_q;

endmodule
`endif

// File: rtl/mirfak_if_stage.sv
// Instruction fetch stage with IF/ID register; inserts NOP bubbles instead of stalling.
// Define MIRFAK_IF_BUFFER_EN to keep a response that arrives while IF/ID is disabled.
module mirfak_if_stage #(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  mirfak_if_stage_if.master        iport,
  input  logic                     xcall_i,
  input  logic [31:0]              xcall_target_i,
  input  logic                     take_branch_i,
  input  logic [31:0]              pc_bj_target_i,
  input  logic                     ifid_enable_i,
  input  logic                     ifid_clear_i,
  output logic [31:0]              id_pc_o,
  output logic [31:0]              id_pc4_o,
  output logic [31:0]              id_instruction_o,
  output logic                     id_if_exception_o,
  output logic [3:0]               id_if_xcause_o,
  output logic                     id_bubble_o
);
  import mirfak_if_stage_pkg::*;

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        cyc_q, cyc_d;

  logic [31:0] id_pc_q, id_pc_d, id_pc4_q, id_pc4_d, id_instr_q, id_instr_d;
  logic        id_exc_q, id_exc_d, id_bubble_q, id_bubble_d;
  logic [3:0]  id_xcause_q, id_xcause_d;

  logic        redirect, resp, valid, consume, advance;
  logic [31:0] target, resp_instr;

  logic        buf_full, buf_full_next, buf_exc;
  logic [31:0] buf_pc, buf_instr;

  assign redirect   = xcall_i | take_branch_i;
  assign target     = xcall_i ? xcall_target_i : pc_bj_target_i;
  assign resp       = cyc_q & (iport.ack | iport.err);
  assign valid      = (state_q == StFetch) & resp & ~redirect;
  assign consume    = valid & ifid_enable_i & ~ifid_clear_i;
  assign resp_instr = iport.err ? NOP : iport.data;

`ifdef MIRFAK_IF_BUFFER_EN
  logic push;
  assign push    = valid & ~ifid_enable_i & ~ifid_clear_i;
  assign advance = consume | push;

  mirfak_if_fetch_buffer u_fetch_buffer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .pop_i       (buf_full & ifid_enable_i),
    .flush_i     (redirect | ifid_clear_i),
    .pc_i        (pc_q),
    .instr_i     (resp_instr),
    .exc_i       (iport.err),
    .full_o      (buf_full),
    .full_next_o (buf_full_next),
    .pc_o        (buf_pc),
    .instr_o     (buf_instr),
    .exc_o       (buf_exc)
  );
`else
  // Without the buffer an unconsumed response is dropped and the same pc is re-requested.
  assign advance       = consume;
  assign buf_full      = 1'b0;
  assign buf_full_next = 1'b0;
  assign buf_pc        = '0;
  assign buf_instr     = NOP;
  assign buf_exc       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    unique case (state_q)
      StReset: begin
        state_d = StFetch;
        if (redirect) pc_d = target;
      end
      StFetch: begin
        if (redirect) begin
          pc_d = target;
          // A transfer in flight must complete before the target can be requested.
          if (cyc_q && !(iport.ack || iport.err)) state_d = StFlush;
        end else if (advance) begin
          pc_d = pc_q + 32'd4;
        end
      end
      StFlush: begin
        if (redirect) pc_d = target;
        if (resp) state_d = StFetch;
      end
      default: state_d = StReset;
    endcase
    if (state_d != StFlush) addr_d = {pc_d[31:2], 2'b00};
    cyc_d = (state_d != StReset) & ~buf_full_next;
  end

  always_comb begin
    id_pc_d     = id_pc_q;
    id_pc4_d    = id_pc4_q;
    id_instr_d  = id_instr_q;
    id_exc_d    = id_exc_q;
    id_xcause_d = id_xcause_q;
    id_bubble_d = id_bubble_q;
    if (ifid_clear_i || ifid_enable_i) begin
      id_pc_d     = '0;
      id_pc4_d    = '0;
      id_instr_d  = NOP;
      id_exc_d    = 1'b0;
      id_xcause_d = '0;
      id_bubble_d = 1'b1;
      if (!ifid_clear_i && !redirect) begin
        if (buf_full) begin
          id_pc_d     = buf_pc;
          id_pc4_d    = buf_pc + 32'd4;
          id_instr_d  = buf_instr;
          id_exc_d    = buf_exc;
          id_xcause_d = buf_exc ? E_INST_ACCESS_FAULT : 4'd0;
          id_bubble_d = 1'b0;
        end else if (valid) begin
          id_pc_d     = pc_q;
          id_pc4_d    = pc_q + 32'd4;
          id_instr_d  = resp_instr;
          id_exc_d    = iport.err;
          id_xcause_d = iport.err ? E_INST_ACCESS_FAULT : 4'd0;
          id_bubble_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= StReset;
      pc_q        <= RESET_ADDR;
      addr_q      <= RESET_ADDR;
      cyc_q       <= 1'b0;
      id_pc_q     <= '0;
      id_pc4_q    <= '0;
      id_instr_q  <= NOP;
      id_exc_q    <= 1'b0;
      id_xcause_q <= '0;
      id_bubble_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      cyc_q       <= cyc_d;
      id_pc_q     <= id_pc_d;
      id_pc4_q    <= id_pc4_d;
      id_instr_q  <= id_instr_d;
      id_exc_q    <= id_exc_d;
      id_xcause_q <= id_xcause_d;
      id_bubble_q <= id_bubble_d;
    end
  end

  assign iport.addr        = addr_q;
  assign iport.cyc         = cyc_q;
  assign iport.stb         = cyc_q;
  assign id_pc_o           = id_pc_q;
  assign id_pc4_o          = id_pc4_q;
  assign id_instruction_o  = id_instr_q;
  assign id_if_exception_o = id_exc_q;
  assign id_if_xcause_o    = id_xcause_q;
  assign id_bubble_o       = id_bubble_q;

endmodule
